// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : boot_pkg
// Purpose  : Shared types and constants for the boot loader: the loader
//            state encoding, default instruction-memory depth, the number
//            of bytes per header field and the 32-bit word type.
// Macros   : BOOT_CHECKSUM_EN (S_CSUM is only reached when defined)
// Revision : 1.0 - initial release
// ============================================================================
package boot_pkg;

  localparam int MEM_INST_SIZE_DEF = 1024;
  localparam int HDR_BYTES         = 4;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_ENTRY = 3'd1,
    S_WORDS = 3'd2,
    S_CSUM  = 3'd3,
    S_RUN   = 3'd4,
    S_ERROR = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/boot_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : boot_byte_fifo
// Purpose  : First-word fall-through byte FIFO. The head byte and the empty
//            flag come straight from the storage/pointer state.
// Ports    : clk, rst        clock, async active-high reset
//            push, push_data write request and byte
//            pop             remove head (ignored when empty)
//            head            current head byte
//            empty, full     occupancy flags
// Notes    : A push while full is accepted only when a pop happens in the
//            same cycle; otherwise it is silently discarded here and the
//            caller flags the overflow.
// Revision : 1.0 - initial release
// ============================================================================
module boot_byte_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // One extra pointer bit separates full (MSBs differ) from empty (equal).
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        do_push;
  logic        do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/boot_controller.sv
`default_nettype none
// ============================================================================
// Module   : boot_controller
// Purpose  : Parses a framed program image from the UART byte stream
//            (word count, entry PC, big-endian words), writes it into
//            instruction memory, then releases the core and forwards later
//            UART bytes to it through a small FIFO.
// Ports    : CLK, INITIALIZE          clock, async active-high reset
//            rx_data, rx_valid        received byte and its strobe
//            imem_we/addr/wdata       instruction-memory write port
//            cpu_run, pc_init         core release and entry PC
//            cpu_rx_data/valid/ready  RUN-phase byte stream to the core
//            load_error, rx_overflow  sticky error flags
// Macros   : BOOT_CHECKSUM_EN - adds a 4-byte checksum trailer (mod 2^32
//            sum of all words) checked before the core is released.
// Revision : 1.0 - initial release
// ============================================================================
module boot_controller
  import boot_pkg::*;
#(
  parameter int MEM_INST_SIZE = MEM_INST_SIZE_DEF,
  parameter int ADDR_W        = 10,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic              CLK,
  input  logic              INITIALIZE,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic [31:0]       pc_init,
  output logic [7:0]        cpu_rx_data,
  output logic              cpu_rx_valid,
  input  logic              cpu_rx_ready,
  output logic              load_error,
  output logic              rx_overflow
);

  localparam logic [1:0] LAST_BYTE = 2'(HDR_BYTES - 1);

  state_t              state_q, state_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         shreg_q, shreg_d;
  logic [ADDR_W:0]     n_q, n_d;
  word_t               pc_q, pc_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  word_t               imem_wdata_q, imem_wdata_d;
  logic                cpu_run_q, cpu_run_d;
  logic                load_error_q, load_error_d;
  logic                rx_overflow_q, rx_overflow_d;
`ifdef BOOT_CHECKSUM_EN
  word_t               csum_q, csum_d;
`endif

  word_t               field;
  logic                field_done;
  logic                parsing;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_empty;
  logic                fifo_full;

  // The current byte completes the field combinationally, so each field is
  // acted upon in the same cycle its last byte arrives (full-rate input).
  assign field     = {shreg_q, rx_data};
  assign parsing   = (state_q == S_LEN) || (state_q == S_ENTRY) ||
                     (state_q == S_WORDS) || (state_q == S_CSUM);
  assign fifo_push = (state_q == S_RUN) && rx_valid;
  assign fifo_pop  = cpu_rx_valid && cpu_rx_ready;

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    shreg_d       = shreg_q;
    n_d           = n_q;
    pc_d          = pc_q;
    word_idx_d    = word_idx_q;
    imem_we_d     = 1'b0;
    imem_addr_d   = imem_addr_q;
    imem_wdata_d  = imem_wdata_q;
    field_done    = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    csum_d        = csum_q;
`endif

    if (parsing && rx_valid) begin
      byte_idx_d = byte_idx_q + 2'd1;
      shreg_d    = field[23:0];
      field_done = (byte_idx_q == LAST_BYTE);
    end

    unique case (state_q)
      S_LEN: begin
        if (field_done) begin
          if ((field == '0) || (field > word_t'(MEM_INST_SIZE))) begin
            state_d = S_ERROR;
          end else begin
            n_d     = field[ADDR_W:0];
            state_d = S_ENTRY;
          end
        end
      end
      S_ENTRY: begin
        if (field_done) begin
          if (field >= word_t'(n_q)) begin
            state_d = S_ERROR;
          end else begin
            pc_d    = field;
            state_d = S_WORDS;
          end
        end
      end
      S_WORDS: begin
        if (field_done) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = word_idx_q;
          imem_wdata_d = field;
          word_idx_d   = word_idx_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
          csum_d       = csum_q + field;
`endif
          if ({1'b0, word_idx_q} == (n_q - (ADDR_W+1)'(1))) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_RUN;
`endif
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CSUM: begin
        if (field_done) begin
          state_d = (field == csum_q) ? S_RUN : S_ERROR;
        end
      end
`endif
      default: state_d = state_q;
    endcase

    // cpu_run lags entry to S_RUN by one cycle, so it rises the cycle after
    // the final write pulse.
    cpu_run_d     = (state_q == S_RUN);
    load_error_d  = load_error_q | (state_d == S_ERROR);
    rx_overflow_d = rx_overflow_q | (fifo_push && fifo_full && !fifo_pop);
  end

  always_ff @(posedge CLK or posedge INITIALIZE) begin
    if (INITIALIZE) begin
      state_q       <= S_LEN;
      byte_idx_q    <= '0;
      shreg_q       <= '0;
      n_q           <= '0;
      pc_q          <= '0;
      word_idx_q    <= '0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      cpu_run_q     <= 1'b0;
      load_error_q  <= 1'b0;
      rx_overflow_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      shreg_q       <= shreg_d;
      n_q           <= n_d;
      pc_q          <= pc_d;
      word_idx_q    <= word_idx_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      cpu_run_q     <= cpu_run_d;
      load_error_q  <= load_error_d;
      rx_overflow_q <= rx_overflow_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  boot_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (INITIALIZE),
    .push      (fifo_push),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .head      (cpu_rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign cpu_rx_valid = !fifo_empty;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_run      = cpu_run_q;
  assign pc_init      = pc_q;
  assign load_error   = load_error_q;
  assign rx_overflow  = rx_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_controller
// Purpose  : Self-checking bench for boot_controller. A reference model
//            computes expected memory writes and RUN-phase bytes from the
//            image byte stream; a monitor pops and compares them as the
//            design presents them.
// Macros   : BOOT_CHECKSUM_EN (bench follows the design build)
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_controller;

  localparam int MEM = 1024;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        INITIALIZE;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic [31:0] pc_init;
  logic [7:0]  cpu_rx_data;
  logic        cpu_rx_valid;
  logic        cpu_rx_ready;
  logic        load_error;
  logic        rx_overflow;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  img[$];
  wr_t         exp_wr_q[$];
  logic [7:0]  exp_fifo_q[$];
  logic        exp_err;
  logic        exp_run;
  logic [31:0] exp_pc;
  wr_t         got_wr;
  logic [7:0]  got_byte;

  always #5 clk = ~clk;

  boot_controller dut (
    .CLK          (clk),
    .INITIALIZE   (INITIALIZE),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_run      (cpu_run),
    .pc_init      (pc_init),
    .cpu_rx_data  (cpu_rx_data),
    .cpu_rx_valid (cpu_rx_valid),
    .cpu_rx_ready (cpu_rx_ready),
    .load_error   (load_error),
    .rx_overflow  (rx_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every write and every consumed byte against the queues.
  always @(negedge clk) begin
    if (!INITIALIZE) begin
      if (imem_we) begin
        tests++;
        if (exp_wr_q.size() == 0) begin
          fails++;
          $display("FAIL imem_write: unexpected addr %0d data %h, none expected", imem_addr, imem_wdata);
        end else begin
          got_wr = exp_wr_q.pop_front();
          if (imem_addr !== got_wr.a || imem_wdata !== got_wr.d) begin
            fails++;
            $display("FAIL imem_write: got addr %0d data %h expected addr %0d data %h",
                     imem_addr, imem_wdata, got_wr.a, got_wr.d);
          end
        end
      end
      if (cpu_rx_valid && cpu_rx_ready) begin
        tests++;
        if (exp_fifo_q.size() == 0) begin
          fails++;
          $display("FAIL cpu_rx: unexpected byte %h, none expected", cpu_rx_data);
        end else begin
          got_byte = exp_fifo_q.pop_front();
          if (cpu_rx_data !== got_byte) begin
            fails++;
            $display("FAIL cpu_rx: got %h expected %h", cpu_rx_data, got_byte);
          end
        end
      end
    end
  end

  function automatic logic [31:0] get_word(input int i);
    return {img[i], img[i+1], img[i+2], img[i+3]};
  endfunction

  task automatic push_word(input logic [31:0] w);
    img.push_back(w[31:24]);
    img.push_back(w[23:16]);
    img.push_back(w[15:8]);
    img.push_back(w[7:0]);
  endtask

  // Reference model: interprets the whole (possibly partial) byte stream
  // by field offsets and fills the expectation queues.
  task automatic model_stream();
    int          nb;
    int          body;
    logic [31:0] n;
    logic [31:0] pc;
    logic [31:0] w;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum;
    sum = 0;
`endif
    nb      = img.size();
    exp_err = 1'b0;
    exp_run = 1'b0;
    exp_pc  = 32'd0;
    if (nb < 4) return;
    n = get_word(0);
    if (n == 0 || n > MEM) begin
      exp_err = 1'b1;
      return;
    end
    if (nb < 8) return;
    pc = get_word(4);
    if (pc >= n) begin
      exp_err = 1'b1;
      return;
    end
    exp_pc = pc;
    for (int k = 0; k < int'(n) && 8 + 4 * k + 4 <= nb; k++) begin
      w = get_word(8 + 4 * k);
`ifdef BOOT_CHECKSUM_EN
      sum = sum + w;
`endif
      exp_wr_q.push_back('{a: 10'(k), d: w});
    end
    body = 8 + 4 * int'(n);
    if (nb < body) return;
`ifdef BOOT_CHECKSUM_EN
    if (nb < body + 4) return;
    if (get_word(body) != sum) begin
      exp_err = 1'b1;
      return;
    end
    body = body + 4;
`endif
    exp_run = 1'b1;
    for (int i = body; i < nb; i++) exp_fifo_q.push_back(img[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_range(input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) idle();
      send_byte(img[i]);
    end
  endtask

  task automatic finish_image(input string tag);
    idle();
    repeat (4) @(negedge clk);
    check({tag, " load_error"}, {31'd0, load_error}, {31'd0, exp_err});
    check({tag, " cpu_run"}, {31'd0, cpu_run}, {31'd0, exp_run});
    check({tag, " pc_init"}, pc_init, exp_pc);
    check({tag, " pending_writes"}, exp_wr_q.size(), 0);
    check({tag, " pending_bytes"}, exp_fifo_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    INITIALIZE = 1'b1;
    rx_valid   = 1'b0;
    @(posedge clk);
    #1;
    INITIALIZE = 1'b0;
    exp_wr_q.delete();
    exp_fifo_q.delete();
    img.delete();
  endtask

  task automatic add_trailer(input logic [31:0] csum);
`ifdef BOOT_CHECKSUM_EN
    push_word(csum);
`else
    if (csum == 32'hFFFF_FFFF) img.push_back(8'h00);
`endif
  endtask

  initial begin
    int n;
    int base;
    logic [31:0] s;
    INITIALIZE   = 1'b1;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    cpu_rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset imem_we", {31'd0, imem_we}, 0);
    check("reset cpu_run", {31'd0, cpu_run}, 0);
    check("reset pc_init", pc_init, 0);
    check("reset load_error", {31'd0, load_error}, 0);
    check("reset rx_overflow", {31'd0, rx_overflow}, 0);
    check("reset cpu_rx_valid", {31'd0, cpu_rx_valid}, 0);
    @(posedge clk);
    #1;
    INITIALIZE = 1'b0;

    // Basic two-word image, full rate, with cycle-exact release timing.
    push_word(32'd2); push_word(32'd1);
    push_word(32'h12345678); push_word(32'hDEADBEEF);
    add_trailer(32'hF0E21567);
    model_stream();
    send_range(0, img.size() - 1, 1'b0);
    idle();
    @(negedge clk);
`ifndef BOOT_CHECKSUM_EN
    check("basic last_we", {31'd0, imem_we}, 1);
`endif
    check("basic run_before", {31'd0, cpu_run}, 0);
    @(negedge clk);
    check("basic run_after", {31'd0, cpu_run}, 1);
    finish_image("basic");

    // Header errors: N too large, N zero, entry out of range.
    for (int t = 0; t < 3; t++) begin
      do_reset();
      push_word(t == 0 ? 32'h0000_0401 : (t == 1 ? 32'd0 : 32'd3));
      push_word(32'd3);
      push_word(32'h1111_1111); push_word(32'h2222_2222); push_word(32'h3333_3333);
      model_stream();
      base = (t == 2) ? 7 : 3;
      send_range(0, base - 1, 1'b0);
      idle();
      @(negedge clk);
      check("err early", {31'd0, load_error}, 0);
      send_range(base, base, 1'b0);
      idle();
      @(negedge clk);
      check("err flag", {31'd0, load_error}, 1);
      send_range(base + 1, img.size() - 1, 1'b0);
      finish_image("err");
    end

    // FIFO fill and overflow, then drain in order.
    do_reset();
    cpu_rx_ready = 1'b0;
    push_word(32'd1); push_word(32'd0); push_word(32'h0BAD_F00D);
    add_trailer(32'h0BAD_F00D);
    base = img.size();
    for (int i = 0; i < 17; i++) img.push_back(8'(i));
    model_stream();
    void'(exp_fifo_q.pop_back());
    send_range(0, base + 15, 1'b0);
    idle();
    @(negedge clk);
    check("ovf before", {31'd0, rx_overflow}, 0);
    check("ovf head", {24'd0, cpu_rx_data}, 0);
    send_range(base + 16, base + 16, 1'b0);
    idle();
    @(negedge clk);
    check("ovf flag", {31'd0, rx_overflow}, 1);
    check("ovf valid", {31'd0, cpu_rx_valid}, 1);
    @(posedge clk);
    #1;
    cpu_rx_ready = 1'b1;
    repeat (16) @(negedge clk);
    @(negedge clk);
    check("drain empty", {31'd0, cpu_rx_valid}, 0);
    check("drain count", exp_fifo_q.size(), 0);
    finish_image("ovf");

    // Asynchronous reset in the middle of the word stream.
    do_reset();
    push_word(32'd2); push_word(32'd1); push_word(32'hA5A5_0001);
    img.push_back(8'h77);
    model_stream();
    send_range(0, img.size() - 1, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    check("midrst pc_before", pc_init, 1);
    #2;
    INITIALIZE = 1'b1;
    #1;
    check("midrst pc", pc_init, 0);
    check("midrst we", {31'd0, imem_we}, 0);
    check("midrst pending", exp_wr_q.size(), 0);
    @(posedge clk);
    #1;
    INITIALIZE = 1'b0;
    img.delete();
    push_word(32'd1); push_word(32'd0); push_word(32'hCAFE_F00D);
    add_trailer(32'hCAFE_F00D);
    model_stream();
    send_range(0, img.size() - 1, 1'b0);
    finish_image("midrst");

`ifdef BOOT_CHECKSUM_EN
    for (int t = 0; t < 2; t++) begin
      do_reset();
      push_word(32'd2); push_word(32'd0); push_word(32'd1); push_word(32'd2);
      push_word(t == 0 ? 32'd3 : 32'd4);
      model_stream();
      send_range(0, img.size() - 1, 1'b0);
      finish_image("csum");
    end
`endif

    // Randomised images with random gaps; some headers are malformed.
    for (int r = 0; r < 20; r++) begin
      do_reset();
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 9) == 0) push_word(32'd0);
      else push_word(32'(n));
      if ($urandom_range(0, 6) == 0) push_word(32'(n + $urandom_range(0, 3)));
      else push_word(32'($urandom_range(0, n - 1)));
      s = 0;
      for (int k = 0; k < n; k++) begin
        logic [31:0] w;
        w = $urandom;
        s = s + w;
        push_word(w);
      end
      add_trailer(s);
      repeat ($urandom_range(0, 5)) img.push_back(8'($urandom));
      model_stream();
      send_range(0, img.size() - 1, 1'b1);
      finish_image("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/boot_controller.md
Name: boot_controller

Overview:
- Sequences the boot of the core from the UART byte stream.
- Parses a framed program image (word count, entry PC, big-endian instruction words) and drives instruction-memory writes.
- Releases the core with cpu_run and pc_init once loading completes.
- In the RUN phase, routes later UART bytes to the core's input port through a small FIFO, so one receiver serves both loader and program.

Parameters:
MEM_INST_SIZE, 1024, instruction memory depth in 32-bit words
ADDR_W, 10, imem address width; must equal clog2(MEM_INST_SIZE)
FIFO_DEPTH, 16, RUN-phase byte buffer depth; power of two, at least 2

Ports:
CLK  in  1  system clock
INITIALIZE  in  1  reset, asynchronous, active-high
rx_data  in  8  byte from UART receiver
rx_valid  in  1  one-cycle pulse per received byte
imem_we  out  1  instruction memory write strobe
imem_addr  out  ADDR_W  write word address
imem_wdata  out  32  write data
cpu_run  out  1  core may execute
pc_init  out  32  entry PC for the core
cpu_rx_data  out  8  FIFO head byte
cpu_rx_valid  out  1  FIFO not empty
cpu_rx_ready  in  1  core consumes head byte this cycle
load_error  out  1  sticky, malformed image
rx_overflow  out  1  sticky, RUN byte dropped because FIFO full

Behaviour:
- Reset values (async on INITIALIZE high): state S_LEN, all outputs 0, FIFO empty, byte index 0, word index 0.
- A byte is accepted only in a cycle with rx_valid=1. Bytes within a field are assembled MSB first.
- States and transitions:
  - S_LEN: collect 4 bytes into N.
    - N == 0 or N > MEM_INST_SIZE: go to S_ERROR.
    - Otherwise: go to S_ENTRY.
  - S_ENTRY: collect 4 bytes into pc_init; go to S_WORDS.
    - pc_init must be < N; a violation goes to S_ERROR.
    - pc_init is visible from the cycle after its 4th byte and holds until reset.
  - S_WORDS: collect 4 bytes per word.
    - The cycle after each 4th byte: imem_we=1 for exactly one cycle, imem_addr=word index, imem_wdata=assembled word.
    - Word index then increments.
    - After word N-1 is accepted: go to S_CSUM if BOOT_CHECKSUM_EN is defined, else S_RUN.
  - S_RUN: cpu_run=1 from the cycle after the final imem_we pulse. Every accepted byte is pushed to the FIFO.
  - S_ERROR: load_error=1, cpu_run=0, all bytes ignored, no imem writes. Exit only by reset.
- imem_we is never asserted outside S_WORDS. imem_addr never exceeds N-1.
- FIFO:
  - First-word fall-through: cpu_rx_data=head and cpu_rx_valid=!empty, both combinational from FIFO state.
  - Pop happens when cpu_rx_valid && cpu_rx_ready.
  - Push when full with a pop in the same cycle: accepted.
  - Push when full with no pop: byte dropped and rx_overflow set (sticky).
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- Reset mid-load: all progress is discarded and a new image must be sent from S_LEN. Memory contents are not cleared.
- Back-to-back rx_valid on consecutive cycles must be handled at full rate, with no byte lost.

Optional Feature:
BOOT_CHECKSUM_EN
- Defined: S_CSUM collects 4 bytes and compares them with the mod-2^32 sum of all N words.
  - Equal: go to S_RUN.
  - Mismatch: go to S_ERROR.
- Not defined: there is no S_CSUM state; S_WORDS goes directly to S_RUN, and a 4-byte trailer would be treated as RUN-phase data.

Decomposition:
- Package boot_pkg holds:
  - the state enum (S_LEN, S_ENTRY, S_WORDS, S_CSUM, S_RUN, S_ERROR);
  - the MEM_INST_SIZE default;
  - HDR_BYTES=4 per field;
  - the word_t 32-bit typedef.
- One sub-module, boot_byte_fifo (parameter FIFO_DEPTH, 8-bit, FWFT), instantiated once. Parsing logic stays in boot_controller.

Test Plan:
- Image N=2, entry=1, words 0x12345678 and 0xDEADBEEF, fed one byte per cycle:
  - imem_we pulses with (addr 0, 0x12345678) and then (addr 1, 0xDEADBEEF);
  - cpu_run rises the cycle after the second pulse;
  - pc_init=1.
- N=0x00000401 with MEM_INST_SIZE=1024: load_error=1 after the 4th byte, no imem_we ever, later bytes ignored. Repeat the case with N=0.
- N=3 with entry=3: load_error=1 after the 8th byte.
- In RUN with cpu_rx_ready=0, send 17 bytes 0x00..0x10:
  - FIFO holds 0x00..0x0F and rx_overflow=1;
  - then hold ready=1: bytes 0x00..0x0F drain in order, one per cycle.
- Assert INITIALIZE asynchronously after 5 word bytes, then send a full N=1 image: state restarts at S_LEN and the single write goes to addr 0.
- With BOOT_CHECKSUM_EN defined, N=2 image with words 1 and 2:
  - trailer 0x00000003 gives cpu_run=1;
  - trailer 0x00000004 gives load_error=1 and cpu_run stays 0.
